bus_arbiter: RTL and testbench

- Shares one single-port system bus slave (unified instruction/data RAM or peripheral bus) between two masters.
  - M0 is the data port driven by the mem stage.
  - M1 is the instruction-fetch port driven by pc_reg/if.
- A registered req/ack FSM grants one transaction at a time, with data priority and an anti-starvation limit for fetch.
- Raises a stall request to pipe_ctrl while any master waits, and converts slave hangs into error responses via a timeout.

---
 rtl/bus_arbiter_pkg.sv | 19 +
 rtl/bus_arb_pick.sv | 36 +++
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared types and widths for the two-master bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE = 2'd0,
        BUS_BUSY = 2'd1,
        BUS_RESP = 2'd2
    } bus_state_e;

    typedef enum logic {
        OWNER_DATA = 1'b0,
        OWNER_INST = 1'b1
    } owner_e;

    localparam int SEL_WIDTH    = 4;
    localparam int STARVE_WIDTH = 4;
    localparam int TIMER_WIDTH  = 8;

endpackage

// File: rtl/bus_arb_pick.sv
// rtl/bus_arb_pick.sv - data-priority winner select with fetch anti-starvation count
module bus_arb_pick
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   arb_en,
    input  logic   m0_req,
    input  logic   m1_req,
    output logic   grant,
    output owner_e winner
);

    logic [STARVE_WIDTH-1:0] starve_cnt;
    logic                    pick_m0;

    assign pick_m0 = m0_req && (!m1_req || (starve_cnt < STARVE_WIDTH'(STARVE_LIMIT)));
    assign grant   = arb_en && (m0_req || m1_req);
    assign winner  = pick_m0 ? OWNER_DATA : OWNER_INST;

    // Counts consecutive data grants that left a fetch waiting; any other grant clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (pick_m0 && m1_req) begin
                if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one single-port bus slave between data and fetch masters
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    input  logic [SEL_WIDTH-1:0]  m0_sel_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    input  logic [SEL_WIDTH-1:0]  m1_sel_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  s_req_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_wdata_o,
    output logic [SEL_WIDTH-1:0]  s_sel_o,
    input  logic                  s_ack_i,
    input  logic [DATA_WIDTH-1:0] s_rdata_i,
    output logic                  stallreq_o
);

    localparam bit                     TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(TIMEOUT_EN ? TIMEOUT - 1 : 0);

    bus_state_e              state;
    owner_e                  owner;
    owner_e                  winner;
    logic                    grant;
    logic [TIMER_WIDTH-1:0]  timer;
    logic                    timeout_hit;
    logic                    win_we;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic [SEL_WIDTH-1:0]    win_sel;

    bus_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .arb_en(state == BUS_IDLE),
        .m0_req(m0_req_i),
        .m1_req(m1_req_i),
        .grant (grant),
        .winner(winner)
    );

    always_comb begin
        win_we    = m0_we_i;
        win_addr  = m0_addr_i;
        win_wdata = m0_wdata_i;
        win_sel   = m0_sel_i;
        if (winner == OWNER_INST) begin
            win_we    = m1_we_i;
            win_addr  = m1_addr_i;
            win_wdata = m1_wdata_i;
            win_sel   = m1_sel_i;
        end
    end

    assign timeout_hit = TIMEOUT_EN && (timer == TIMEOUT_LAST);
    assign stallreq_o  = rst_i & ((m0_req_i & ~m0_ack_o) | (m1_req_i & ~m1_ack_o));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= BUS_IDLE;
            owner      <= OWNER_DATA;
            timer      <= '0;
            s_req_o    <= 1'b0;
            s_we_o     <= 1'b0;
            s_addr_o   <= '0;
            s_wdata_o  <= '0;
            s_sel_o    <= '0;
            m0_ack_o   <= 1'b0;
            m0_err_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_ack_o   <= 1'b0;
            m1_err_o   <= 1'b0;
            m1_rdata_o <= '0;
        end else begin
            m0_ack_o <= 1'b0;
            m0_err_o <= 1'b0;
            m1_ack_o <= 1'b0;
            m1_err_o <= 1'b0;
            case (state)
                BUS_IDLE: begin
                    if (grant) begin
                        owner     <= winner;
                        s_req_o   <= 1'b1;
                        s_we_o    <= win_we;
                        s_addr_o  <= win_addr;
                        s_wdata_o <= win_wdata;
                        s_sel_o   <= win_sel;
                        timer     <= '0;
                        state     <= BUS_BUSY;
                    end
                end
                BUS_BUSY: begin
                    // A slave ack in the expiry cycle still counts as a clean completion.
                    if (s_ack_i) begin
                        s_req_o <= 1'b0;
                        state   <= BUS_RESP;
                        if (owner == OWNER_DATA) begin
                            m0_ack_o   <= 1'b1;
                            m0_rdata_o <= s_rdata_i;
                        end else begin
                            m1_ack_o   <= 1'b1;
                            m1_rdata_o <= s_rdata_i;
                        end
                    end else if (timeout_hit) begin
                        s_req_o <= 1'b0;
                        state   <= BUS_RESP;
                        if (owner == OWNER_DATA) begin
                            m0_ack_o   <= 1'b1;
                            m0_err_o   <= 1'b1;
                            m0_rdata_o <= '0;
                        end else begin
                            m1_ack_o   <= 1'b1;
                            m1_err_o   <= 1'b1;
                            m1_rdata_o <= '0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                BUS_RESP: state <= BUS_IDLE;
                default:  state <= BUS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized scoreboard bench for bus_arbiter
module tb_bus_arbiter;

    localparam int LIMIT = 4;
    localparam int TMO   = 8;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req, m0_we, m0_ack, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_sel;
    logic        m1_req, m1_we, m1_ack, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_sel;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_sel;
    logic        s_ack = 1'b0;
    logic [31:0] s_rdata = '0;
    logic        stallreq;

    logic        req [2] = '{1'b0, 1'b0};
    req_t        cur [2] = '{'0, '0};
    int          gap [2] = '{0, 0};
    wire  [1:0]  acks = {m1_ack, m0_ack};
    bit          burst = 1'b1;
    bit          stop = 1'b0;
    int          cyc = 0;

    resp_t       resp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    assign m0_req = req[0];
    assign m0_we = cur[0].we;
    assign m0_addr = cur[0].addr;
    assign m0_wdata = cur[0].wdata;
    assign m0_sel = cur[0].sel;
    assign m1_req = req[1];
    assign m1_we = cur[1].we;
    assign m1_addr = cur[1].addr;
    assign m1_wdata = cur[1].wdata;
    assign m1_sel = cur[1].sel;

    bus_arbiter #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(LIMIT),
        .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_sel_i(m0_sel), .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_sel_i(m1_sel), .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
        .s_sel_o(s_sel), .s_ack_i(s_ack), .s_rdata_i(s_rdata), .stallreq_o(stallreq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic req_t new_req();
        req_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = $urandom;
        t.wdata = $urandom;
        t.sel   = 4'($urandom);
        return t;
    endfunction

    // Masters: hold a request until acked, then re-issue at once or after a gap.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] && acks[i]) begin
                    if (!stop && (burst || $urandom_range(0, 2) == 0)) cur[i] = new_req();
                    else begin
                        req[i] = 1'b0;
                        gap[i] = burst ? 0 : $urandom_range(0, 4);
                    end
                end else if (!req[i] && !stop) begin
                    if (gap[i] == 0) begin
                        req[i] = 1'b1;
                        cur[i] = new_req();
                    end else gap[i]--;
                end
            end
        end
    end

    // Slave: random latency 1..TMO, occasional hang, stray acks while not requested.
    int slv_lat = 0, slv_j = 0;
    bit slv_active = 1'b0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            s_ack = 1'b0;
            slv_active = 1'b0;
        end else if (!s_req) begin
            slv_active = 1'b0;
            s_ack = ($urandom_range(0, 3) == 0);
            s_rdata = $urandom;
        end else begin
            if (!slv_active) begin
                slv_active = 1'b1;
                slv_j = 1;
                slv_lat = burst ? 1 : (($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TMO));
                if (slv_lat == 0) resp_q.push_back('{1'b1, 32'h0, cyc + TMO});
            end else slv_j++;
            s_ack = 1'b0;
            s_rdata = $urandom;
            if (slv_lat != 0 && slv_j == slv_lat) begin
                s_ack = 1'b1;
                resp_q.push_back('{1'b0, s_rdata, cyc + 1});
            end
        end
    end

    // Monitor: transaction-level arbiter model plus response scoreboard.
    bit          in_flight = 1'b0, idle_prev = 1'b1, exp_owner = 1'b0, ack_now, e0, e1;
    int          streak = 0;
    req_t        exp_fields = '0, prev_cur0 = '0, prev_cur1 = '0;
    logic        prev_req0 = 1'b0, prev_req1 = 1'b0;
    logic [31:0] last_rd [2] = '{32'h0, 32'h0};
    resp_t       r;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_s_req", 72'(s_req), 72'(0));
            chk("rst_ack_err", 72'({m1_ack, m0_ack, m1_err, m0_err}), 72'(0));
            chk("rst_stallreq", 72'(stallreq), 72'(0));
            in_flight = 1'b0;
            idle_prev = 1'b1;
            streak = 0;
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else begin
            if (idle_prev && (prev_req0 || prev_req1)) begin
                exp_owner = !(prev_req0 && (!prev_req1 || streak < LIMIT));
                if (!exp_owner && prev_req1) streak = (streak < 15) ? streak + 1 : 15;
                else streak = 0;
                exp_fields = exp_owner ? prev_cur1 : prev_cur0;
                in_flight = 1'b1;
            end
            while (resp_q.size() > 0 && resp_q[0].cyc < cyc) begin
                chk("ack_missing", 72'(0), 72'(1));
                void'(resp_q.pop_front());
            end
            ack_now = in_flight && resp_q.size() > 0 && resp_q[0].cyc == cyc;
            if (ack_now) r = resp_q.pop_front();
            else r = '{1'b0, 32'h0, 0};
            e0 = ack_now && !exp_owner;
            e1 = ack_now && exp_owner;
            chk("m0_ack", 72'(m0_ack), 72'(e0));
            chk("m1_ack", 72'(m1_ack), 72'(e1));
            chk("m0_err", 72'(m0_err), 72'(e0 && r.err));
            chk("m1_err", 72'(m1_err), 72'(e1 && r.err));
            if (e0) last_rd[0] = r.err ? 32'h0 : r.rdata;
            if (e1) last_rd[1] = r.err ? 32'h0 : r.rdata;
            chk("m0_rdata", 72'(m0_rdata), 72'(last_rd[0]));
            chk("m1_rdata", 72'(m1_rdata), 72'(last_rd[1]));
            if (ack_now) in_flight = 1'b0;
            chk("s_req", 72'(s_req), 72'(in_flight));
            if (in_flight) chk("s_fields", 72'({s_we, s_addr, s_wdata, s_sel}), 72'(exp_fields));
            chk("stallreq", 72'(stallreq), 72'((req[0] && !e0) || (req[1] && !e1)));
            idle_prev = !in_flight && !ack_now;
        end
        prev_req0 = req[0];
        prev_req1 = req[1];
        prev_cur0 = cur[0];
        prev_cur1 = cur[1];
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (80) @(negedge clk);
        burst = 1'b0;
        repeat (1500) @(negedge clk);

        for (int i = 0; i < 100 && !s_req; i++) @(negedge clk);
        chk("busy_before_reset", 72'(s_req), 72'(1));
        @(posedge clk);
        #3 rst_n = 1'b0;
        resp_q.delete();
        #1;
        chk("async_s_req", 72'(s_req), 72'(0));
        chk("async_ack_err", 72'({m1_ack, m0_ack, m1_err, m0_err}), 72'(0));
        chk("async_stallreq", 72'(stallreq), 72'(0));
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (600) @(negedge clk);

        stop = 1'b1;
        repeat (60) @(negedge clk);
        chk("drain_queue", 72'(resp_q.size()), 72'(0));
        chk("drain_idle", 72'(in_flight), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
